// File: rtl/xbar_route_scheduler.sv
// Round-robin route scheduler: grants one requester, programs the shared crossbar
// control word over val/rdy, then holds the route for a counted burst of beats.
module xbar_route_scheduler #(
    parameter int unsigned N_INPUTS          = 2,
    parameter int unsigned N_OUTPUTS         = 2,
    parameter int unsigned CONTROL_BIT_WIDTH = 42,
    parameter int unsigned LEN_W             = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [N_INPUTS-1:0]                   req_val,
    output logic [N_INPUTS-1:0]                   req_rdy,
    input  logic [N_INPUTS*$clog2(N_OUTPUTS)-1:0] req_dest,
    input  logic [N_INPUTS*LEN_W-1:0]             req_len,
    output logic [CONTROL_BIT_WIDTH-1:0]          control,
    output logic                                  control_val,
    input  logic                                  control_rdy,
    input  logic [N_INPUTS-1:0]                   mon_val,
    input  logic [N_INPUTS-1:0]                   mon_rdy,
    output logic                                  busy,
    output logic [N_INPUTS-1:0]                   grant,
    output logic                                  done
);
    localparam int unsigned OW = $clog2(N_OUTPUTS);
    localparam int unsigned IW = $clog2(N_INPUTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_SETTLE,
        S_XFER,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      sel_in_q, sel_in_d;
    logic [OW-1:0]      sel_out_q, sel_out_d;
    logic [LEN_W-1:0]   rem_q, rem_d;

    logic [OW-1:0]      dest_a [N_INPUTS];
    logic [LEN_W-1:0]   len_a  [N_INPUTS];
    logic               found_c;
    logic [IW-1:0]      pick_c;
    logic               beat_c;

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_slice
        assign dest_a[g] = req_dest[g*OW +: OW];
        assign len_a[g]  = req_len[g*LEN_W +: LEN_W];
    end

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int unsigned k);
        return IW'((32'(base) + k) % N_INPUTS);
    endfunction

    // First pending requester at or after the rotating pointer
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        for (int unsigned k = 0; k < N_INPUTS; k++) begin
            if (!found_c && req_val[rr_idx(rr_ptr_q, k)]) begin
                found_c = 1'b1;
                pick_c  = rr_idx(rr_ptr_q, k);
            end
        end
    end

    assign beat_c = mon_val[sel_in_q] & mon_rdy[sel_in_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            sel_in_q  <= '0;
            sel_out_q <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            sel_in_q  <= sel_in_d;
            sel_out_q <= sel_out_d;
            rem_q     <= rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        sel_in_d  = sel_in_q;
        sel_out_d = sel_out_q;
        rem_d     = rem_q;
        req_rdy   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    req_rdy[pick_c] = 1'b1;
                    sel_in_d        = pick_c;
                    sel_out_d       = dest_a[pick_c];
                    rem_d           = len_a[pick_c];
                    state_d         = S_CFG;
                end
            end
            S_CFG: begin
                if (control_rdy) state_d = S_SETTLE;
            end
            // crossbar registers the word on this edge; route is live next cycle
            S_SETTLE: state_d = S_XFER;
            S_XFER: begin
                if (beat_c) begin
                    if (rem_q == '0) state_d = S_DONE;
                    else             rem_d   = rem_q - LEN_W'(1);
                end
            end
            S_DONE: begin
                rr_ptr_d = (sel_in_q == IW'(N_INPUTS - 1)) ? '0 : sel_in_q + IW'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign control_val = (state_q == S_CFG);
    assign control     = control_val ? CONTROL_BIT_WIDTH'({sel_in_q, sel_out_q}) : '0;
    assign busy        = (state_q != S_IDLE);
    assign grant       = busy ? (N_INPUTS'(1) << sel_in_q) : '0;
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_xbar_route_scheduler.sv
// Scoreboard bench for xbar_route_scheduler: a transaction driver predicts grants,
// control words and done timing; a negedge monitor pops and compares.
module tb_xbar_route_scheduler;
    localparam int N  = 2;
    localparam int OW = 1;
    localparam int LW = 8;
    localparam int CW = 42;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_val = '0;
    logic [N-1:0]    req_rdy;
    logic [N*OW-1:0] req_dest = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [CW-1:0]   control;
    logic            control_val;
    logic            control_rdy = 1'b0;
    logic [N-1:0]    mon_val = '0;
    logic [N-1:0]    mon_rdy = '0;
    logic            busy;
    logic [N-1:0]    grant;
    logic            done;

    xbar_route_scheduler #(
        .N_INPUTS(N), .N_OUTPUTS(2), .CONTROL_BIT_WIDTH(CW), .LEN_W(LW)
    ) dut (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
        .req_dest(req_dest), .req_len(req_len), .control(control),
        .control_val(control_val), .control_rdy(control_rdy),
        .mon_val(mon_val), .mon_rdy(mon_rdy), .busy(busy), .grant(grant), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int model_ptr = 0;

    int            acc_q[$];
    logic [CW-1:0] ctl_q[$];
    int            ctlw_q[$];
    int            dcyc_q[$];
    int            dw_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int w);
        return N'(1) << w;
    endfunction

    // Reference arbitration: first requester from the rotating pointer
    function automatic int winner(input logic [N-1:0] rv);
        for (int k = 0; k < N; k++) begin
            if (rv[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_val = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic txn(input logic [N-1:0] rv, input logic [N*OW-1:0] dst,
                       input logic [N*LW-1:0] ln, input int stall,
                       input bit hold, input bit dense);
        int w, need, cnt;
        logic [OW-1:0] d;
        w    = winner(rv);
        d    = dst[w*OW +: OW];
        need = int'(ln[w*LW +: LW]) + 1;
        acc_q.push_back(w);
        ctl_q.push_back(CW'((w << OW) | int'(d)));
        ctlw_q.push_back(w);
        req_val = rv; req_dest = dst; req_len = ln; control_rdy = 1'b0;
        step();
        if (!hold) req_val = '0;
        for (int s = 0; s <= stall; s++) begin
            control_rdy = (s == stall);
            step();
        end
        // settle cycle: random traffic here must not count
        control_rdy = 1'($urandom);
        mon_val = N'($urandom); mon_rdy = N'($urandom);
        step();
        cnt = 0;
        while (cnt < need) begin
            if (dense) begin
                mon_val = '1; mon_rdy = '1;
            end else begin
                mon_val = N'($urandom); mon_rdy = N'($urandom);
            end
            control_rdy = 1'($urandom);
            if (mon_val[w] && mon_rdy[w]) begin
                cnt++;
                if (cnt == need) begin
                    dcyc_q.push_back(cyc + 1);
                    dw_q.push_back(w);
                end
            end
            step();
        end
        mon_val = '0; mon_rdy = '0; control_rdy = 1'b0;
        model_ptr = (w + 1) % N;
        step();
        chk("busy_after_done", 64'({busy, grant}), 64'(0));
    endtask

    logic          prev_cv = 1'b0;
    logic          prev_hs = 1'b0;
    logic [CW-1:0] prev_ctl = '0;

    // Monitor: pop expectations whenever the DUT presents an event
    always @(negedge clk) begin
        if (!reset) begin
            if (|req_rdy) begin
                if (acc_q.size() == 0) chk("req_rdy_unexpected", 64'(req_rdy), 64'(0));
                else chk("req_rdy", 64'(req_rdy), 64'(onehot(acc_q.pop_front())));
            end
            if (control_val && control_rdy) begin
                if (ctl_q.size() == 0) chk("ctl_unexpected", 64'(ctl_q.size()), 64'(1));
                else begin
                    chk("control", 64'(control), 64'(ctl_q.pop_front()));
                    chk("grant_cfg", 64'(grant), 64'(onehot(ctlw_q.pop_front())));
                end
            end
            if (control_val && prev_cv && !prev_hs) chk("ctl_stable", 64'(control), 64'(prev_ctl));
            if (done) begin
                if (dcyc_q.size() == 0) chk("done_unexpected", 64'(dcyc_q.size()), 64'(1));
                else begin
                    chk("done_cycle", 64'(cyc), 64'(dcyc_q.pop_front()));
                    chk("grant_done", 64'(grant), 64'(onehot(dw_q.pop_front())));
                    chk("busy_done", 64'(busy), 64'(1));
                end
            end
        end
        prev_cv  = control_val;
        prev_hs  = control_val & control_rdy;
        prev_ctl = control;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("reset_idle", 64'({req_rdy, control, control_val, busy, grant, done}), 64'(0));
        end

        // single request, dest0=1, len0=3, dense beats
        txn(2'b01, 2'b01, {8'd0, 8'd3}, 0, 1'b0, 1'b1);

        // fairness with both requesters held
        for (int i = 0; i < 4; i++) txn(2'b11, 2'b10, {8'd0, 8'd0}, 0, 1'b1, 1'b1);
        idle(2);

        // backpressure and noisy beats
        txn(2'b01, 2'b01, {8'd5, 8'd2}, 5, 1'b0, 1'b0);
        idle(1);

        // length boundaries
        txn(2'b10, 2'b10, {8'd255, 8'd0}, 0, 1'b0, 1'b1);
        txn(2'b01, 2'b00, {8'd7, 8'd0}, 1, 1'b0, 1'b0);

        // reset mid-burst after 2 of 4 beats
        acc_q.push_back(0); ctl_q.push_back(CW'(1)); ctlw_q.push_back(0);
        req_val = 2'b01; req_dest = 2'b01; req_len = {8'd0, 8'd3};
        step(); req_val = '0; control_rdy = 1'b1;
        step(); control_rdy = 1'b0;
        step(); mon_val = 2'b01; mon_rdy = 2'b01;
        step();
        step(); mon_val = '0; mon_rdy = '0; reset = 1'b1;
        step(); reset = 1'b0;
        chk("reset_mid", 64'({req_rdy, control, control_val, busy, grant, done}), 64'(0));
        model_ptr = 0;
        idle(4);
        txn(2'b11, 2'b11, {8'd1, 8'd1}, 0, 1'b0, 1'b1);

        for (int t = 0; t < 30; t++) begin
            txn(N'($urandom_range(1, 3)), (N*OW)'($urandom),
                {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))},
                int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        idle(3);
        chk("acc_q_left", 64'(acc_q.size()), 64'(0));
        chk("ctl_q_left", 64'(ctl_q.size()), 64'(0));
        chk("done_q_left", 64'(dcyc_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
